// File: rtl/rnr_rr_skid_reg_if.sv
// Handshake and data bundle between register rename and register read.
// The slave modport is the skid register's view. The master modport is the
// view of the surrounding pipeline, which drives rename's side and consumes the head.
interface rnr_rr_skid_reg_if #(
    parameter int WIDTH   = 165,
    parameter int DEPTH_W = 2
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   ifmt1_in;
    logic [WIDTH-1:0]   ifmt2_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   ifmt1_out;
    logic [WIDTH-1:0]   ifmt2_out;
    logic [DEPTH_W-1:0] occupancy;

    modport slave (
        input  flush, in_valid, ifmt1_in, ifmt2_in, out_ready,
        output in_ready, out_valid, ifmt1_out, ifmt2_out, occupancy
    );

    modport master (
        output flush, in_valid, ifmt1_in, ifmt2_in, out_ready,
        input  in_ready, out_valid, ifmt1_out, ifmt2_out, occupancy
    );
endinterface

// File: rtl/rnr_rr_skid_reg.sv
// Rename -> register-read boundary register with a 2-entry skid buffer.
// in_ready is decoded only from registered state, so a register-read stall
// never forms a combinational path back into rename. Bubbles (both lane-valid
// bits clear) complete the handshake but are never stored.
module rnr_rr_skid_reg #(
    parameter int WIDTH   = 165,
    parameter int DEPTH_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    rnr_rr_skid_reg_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   main1;
    logic [WIDTH-1:0]   main2;
    logic [WIDTH-1:0]   skid1;
    logic [WIDTH-1:0]   skid2;

    logic               in_ready_int;
    logic               out_valid_int;
    logic [DEPTH_W-1:0] occ;
    logic               acc;
    logic               pop;
    logic               main_load_in;
    logic               main_load_skid;
    logic               skid_load;

    // Output decode from the registered state only.
    always_comb begin
        in_ready_int  = 1'b1;
        out_valid_int = 1'b0;
        occ           = '0;
        case (state)
            EMPTY: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
                occ           = DEPTH_W'(0);
            end
            ONE: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b1;
                occ           = DEPTH_W'(1);
            end
            TWO: begin
                in_ready_int  = 1'b0;
                out_valid_int = 1'b1;
                occ           = DEPTH_W'(2);
            end
            default: begin
                in_ready_int  = 1'b1;
                out_valid_int = 1'b0;
                occ           = '0;
            end
        endcase
    end

    // Next-state and entry-load decode; a flush cancels both accept and pop.
    always_comb begin
        acc            = bus.in_valid & in_ready_int & ~bus.flush &
                         (bus.ifmt1_in[WIDTH-1] | bus.ifmt2_in[WIDTH-1]);
        pop            = out_valid_int & bus.out_ready & ~bus.flush;
        state_nxt      = state;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_load_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (acc && pop) begin
                        main_load_in = 1'b1;
                        state_nxt    = ONE;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_load_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head and skid entries; flush leaves them stale since out_valid qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main1 <= '0;
            main2 <= '0;
            skid1 <= '0;
            skid2 <= '0;
        end else begin
            if (main_load_in) begin
                main1 <= bus.ifmt1_in;
                main2 <= bus.ifmt2_in;
            end else if (main_load_skid) begin
                main1 <= skid1;
                main2 <= skid2;
            end
            if (skid_load) begin
                skid1 <= bus.ifmt1_in;
                skid2 <= bus.ifmt2_in;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.ifmt1_out = main1;
    assign bus.ifmt2_out = main2;
    assign bus.occupancy = occ;

endmodule

// File: tb/tb_rnr_rr_skid_reg.sv
// Bench for the rename -> register-read skid register: directed vector table,
// hand-written corner sequences, and a random phase against a queue model.
module tb_rnr_rr_skid_reg;

    localparam int WIDTH = 165;

    typedef struct packed {
        logic [WIDTH-1:0] l1;
        logic [WIDTH-1:0] l2;
    } pair_t;

    typedef struct {
        logic       in_valid;
        logic       v1;
        logic       v2;
        logic [7:0] tag;
        logic       out_ready;
        logic       flush;
        logic [1:0] exp_occ;
        logic [7:0] exp_tag;
        logic       exp_v1;
        logic       exp_v2;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    pair_t model_q[$];
    vec_t  vecs[11];

    rnr_rr_skid_reg_if #(.WIDTH(WIDTH), .DEPTH_W(2)) bus ();

    rnr_rr_skid_reg #(.WIDTH(WIDTH), .DEPTH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(input logic v, input logic [7:0] tag);
        return {v, {20{tag}}, 4'hA};
    endfunction

    function automatic logic [WIDTH-1:0] rnd_bundle(input logic v);
        logic [WIDTH-1:0] b;
        b = {v, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom())};
        return b;
    endfunction

    task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_occ, input logic e_ovalid,
                               input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
        cmp({name, ".occupancy"}, WIDTH'(bus.occupancy), WIDTH'(e_occ));
        cmp({name, ".in_ready"},  WIDTH'(bus.in_ready),  WIDTH'(e_occ != 2'd2));
        cmp({name, ".out_valid"}, WIDTH'(bus.out_valid), WIDTH'(e_ovalid));
        if (e_ovalid) begin
            cmp({name, ".ifmt1_out"}, bus.ifmt1_out, e1);
            cmp({name, ".ifmt2_out"}, bus.ifmt2_out, e2);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b2,
                                 input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.ifmt1_in  = b1;
        bus.ifmt2_in  = b2;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // Queue model: what the block should hold after an edge with the given inputs.
    task automatic modelStep(input logic iv, input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b2,
                             input logic ordy, input logic fl);
        logic had_room;
        logic had_head;
        pair_t p;
        had_room = (model_q.size() < 2);
        had_head = (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (had_head && ordy) void'(model_q.pop_front());
            if (iv && had_room && (b1[WIDTH-1] || b2[WIDTH-1])) begin
                p.l1 = b1;
                p.l2 = b2;
                model_q.push_back(p);
            end
        end
    endtask

    task automatic checkModel(input string name);
        if (model_q.size() > 0)
            checkOutput(name, 2'(model_q.size()), 1'b1, model_q[0].l1, model_q[0].l2);
        else
            checkOutput(name, 2'd0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] b1;
        logic [WIDTH-1:0] b2;
        logic             iv;
        logic             ordy;
        logic             fl;
        logic             v1;
        logic             v2;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

        //              iv  v1 v2 tag    ordy fl  occ  etag   ev1 ev2
        vecs[0]  = '{1'b1, 1, 1, 8'h01, 1'b0, 0, 2'd1, 8'h01, 1, 1};
        vecs[1]  = '{1'b1, 1, 1, 8'h02, 1'b0, 0, 2'd2, 8'h01, 1, 1};
        vecs[2]  = '{1'b1, 1, 1, 8'h03, 1'b0, 0, 2'd2, 8'h01, 1, 1};
        vecs[3]  = '{1'b0, 1, 1, 8'h33, 1'b1, 0, 2'd1, 8'h02, 1, 1};
        vecs[4]  = '{1'b1, 1, 1, 8'h04, 1'b1, 0, 2'd1, 8'h04, 1, 1};
        vecs[5]  = '{1'b1, 0, 0, 8'h05, 1'b0, 0, 2'd1, 8'h04, 1, 1};
        vecs[6]  = '{1'b1, 0, 1, 8'h06, 1'b0, 0, 2'd2, 8'h04, 1, 1};
        vecs[7]  = '{1'b1, 1, 1, 8'h07, 1'b1, 1, 2'd0, 8'h00, 0, 0};
        vecs[8]  = '{1'b0, 1, 1, 8'h77, 1'b1, 0, 2'd0, 8'h00, 0, 0};
        vecs[9]  = '{1'b1, 1, 0, 8'h08, 1'b1, 0, 2'd1, 8'h08, 1, 0};
        vecs[10] = '{1'b0, 1, 1, 8'h99, 1'b1, 0, 2'd0, 8'h00, 0, 0};

        // Reset state, checked while rst is still high.
        #2;
        checkOutput("reset", 2'd0, 1'b0, '0, '0);
        cmp("reset.ifmt1_out", bus.ifmt1_out, '0);
        cmp("reset.ifmt2_out", bus.ifmt2_out, '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table; expected values hold after the edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].in_valid, mk(vecs[i].v1, vecs[i].tag), mk(vecs[i].v2, ~vecs[i].tag),
                          vecs[i].out_ready, vecs[i].flush);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_occ, vecs[i].exp_occ != 2'd0,
                        mk(vecs[i].exp_v1, vecs[i].exp_tag), mk(vecs[i].exp_v2, ~vecs[i].exp_tag));
        end

        // Streaming with out_ready high: Pk at the head one cycle after it is offered.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, mk(1'b1, 8'h40 + 8'(k)), mk(1'b1, 8'h50 + 8'(k)), 1'b1, 1'b0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream%0d", k), 2'd1, 1'b1, mk(1'b1, 8'h40 + 8'(k)), mk(1'b1, 8'h50 + 8'(k)));
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("stream_drain", 2'd0, 1'b0, '0, '0);

        // Fill to TWO, then assert reset asynchronously between edges.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, mk(1'b1, 8'hC0 + 8'(k)), mk(1'b1, 8'hD0 + 8'(k)), 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        checkOutput("fill_two", 2'd2, 1'b1, mk(1'b1, 8'hC0), mk(1'b1, 8'hD0));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 2'd0, 1'b0, '0, '0);
        cmp("async_reset.ifmt1_out", bus.ifmt1_out, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the queue model.
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checkModel($sformatf("rand%0d", c));
            iv   = ($urandom_range(0, 3) != 0);
            v1   = ($urandom_range(0, 3) != 0);
            v2   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            b1   = rnd_bundle(v1);
            b2   = rnd_bundle(v2);
            applyStimulus(iv, b1, b2, ordy, fl);
            @(posedge clk);
            modelStep(iv, b1, b2, ordy, fl);
        end
        @(negedge clk);
        checkModel("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
